maximas_uart_tx: RTL and testbench

Consumer end of the peak-finder output: snapshots the MAXIMAS_COUNT fingerprint words on each maximas_found_active pulse and serializes them as a framed byte stream over an 8N1 UART line to the host.
Sits directly after shazam_core in the top level and drives the board's TX pin.
One frame per FFT window.
A new pulse that arrives mid-frame is dropped and counted.

---
 rtl/maximas_uart_tx_pkg.sv | 38 +++
 rtl/uart_tx_byte.sv | 61 ++++++
 rtl/maximas_uart_tx.sv | 215 +++++++++++++++++++++
 tb/tb_maximas_uart_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maximas_uart_tx_pkg.sv
// Shared types, constants and byte helpers for the maxima UART transmitter.
// Optional checksum byte is enabled with the MAXIMAS_UART_TX_CHECKSUM_EN macro.
package shazam_tx_pkg;

   localparam logic [7:0] SYNC_BYTE        = 8'hA5;
   localparam int         BYTES_PER_MAXIMA = 4;
   localparam int         MAXIMA_W         = 25;

   typedef logic [MAXIMA_W-1:0] maxima_t;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOAD       = 3'd1,
      SEND_SYNC  = 3'd2,
      SEND_COUNT = 3'd3,
      SEND_DATA  = 3'd4,
      SEND_CSUM  = 3'd5,
      DONE       = 3'd6
   } tx_state_e;

   // Byte b of a maxima word, most significant first; byte 0 carries only bit 24.
   function automatic logic [7:0] maxima_byte(input maxima_t d, input logic [1:0] b);
      logic [7:0] r;
      case (b)
         2'd0:    r = {7'b0000000, d[24]};
         2'd1:    r = d[23:16];
         2'd2:    r = d[15:8];
         default: r = d[7:0];
      endcase
      return r;
   endfunction

   // Running XOR checksum update.
   function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with a valid/ready handshake. Ready rises in the last
// cycle of the stop bit so a waiting byte starts with no idle gap.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic       tx
);

   localparam int             TW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0]  T_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]     STOP_BIT = 4'd9;

   logic          active_r;
   logic [TW-1:0] timer_r;
   logic [3:0]    bit_r;
   logic [7:0]    shift_r;
   logic          tx_r;

   assign byte_ready = !active_r || ((bit_r == STOP_BIT) && (timer_r == T_LAST));
   assign tx         = tx_r;

   // Bit timer, bit index and shift register; ones shift in so the stop bit falls out naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_r <= 1'b0;
         timer_r  <= '0;
         bit_r    <= 4'd0;
         shift_r  <= 8'hFF;
         tx_r     <= 1'b1;
      end else if (byte_valid && byte_ready) begin
         active_r <= 1'b1;
         timer_r  <= '0;
         bit_r    <= 4'd0;
         shift_r  <= byte_in;
         tx_r     <= 1'b0;
      end else if (active_r) begin
         if (timer_r == T_LAST) begin
            timer_r <= '0;
            if (bit_r == STOP_BIT) begin
               active_r <= 1'b0;
               bit_r    <= 4'd0;
               tx_r     <= 1'b1;
            end else begin
               bit_r    <= bit_r + 4'd1;
               tx_r     <= shift_r[0];
               shift_r  <= {1'b1, shift_r[7:1]};
            end
         end else begin
            timer_r <= timer_r + TW'(1);
         end
      end else begin
         tx_r <= 1'b1;
      end
   end

endmodule

// File: rtl/maximas_uart_tx.sv
// Snapshots MAXIMAS_COUNT maxima words on each strobe and sends them as one
// framed 8N1 byte stream: SYNC, COUNT, 4 bytes per entry, optional checksum.
// Define MAXIMAS_UART_TX_CHECKSUM_EN to append the XOR checksum byte.
module maximas_uart_tx
   import shazam_tx_pkg::*;
#(
   parameter int MAXIMAS_COUNT = 11,
   parameter int CLKS_PER_BIT  = 434
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [24:0] maximas [MAXIMAS_COUNT-1:0],
   input  logic        maximas_found_active,
   output logic        tx,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  dropped_frames
);

   localparam int             K_W        = $clog2(MAXIMAS_COUNT + 1);
   localparam logic [K_W-1:0] K_LAST     = K_W'(MAXIMAS_COUNT - 1);
   localparam logic [1:0]     B_LAST     = 2'(BYTES_PER_MAXIMA - 1);
   localparam logic [7:0]     COUNT_BYTE = 8'(MAXIMAS_COUNT);

   tx_state_e      state_r;
   maxima_t        snap_r [MAXIMAS_COUNT-1:0];
   logic [K_W-1:0] k_r;
   logic [1:0]     b_r;
   logic [7:0]     byte_r;
   logic           byte_valid_r;
   logic           busy_r;
   logic           frame_done_r;
   logic [7:0]     dropped_r;
`ifdef MAXIMAS_UART_TX_CHECKSUM_EN
   logic [7:0]     csum_r;
`endif

   logic           byte_ready_s;
   logic           byte_fire_s;
   logic           last_s;
   logic [K_W-1:0] next_k_s;
   logic [1:0]     next_b_s;
   maxima_t        sel_s;
   logic [7:0]     next_byte_s;
   logic [7:0]     first_byte_s;
   logic           tx_s;

   assign byte_fire_s  = byte_valid_r && byte_ready_s;
   assign last_s       = (k_r == K_LAST) && (b_r == B_LAST);
   assign first_byte_s = maxima_byte(snap_r[0], 2'd0);

   // Position and value of the byte that follows the one currently presented.
   always_comb begin
      next_k_s = k_r;
      next_b_s = b_r + 2'd1;
      if (b_r == B_LAST) begin
         next_k_s = k_r + K_W'(1);
         next_b_s = 2'd0;
      end else begin
         next_k_s = k_r;
      end
      sel_s = snap_r[0];
      for (int i = 0; i < MAXIMAS_COUNT; i++) begin
         sel_s = (next_k_s == K_W'(i)) ? snap_r[i] : sel_s;
      end
      next_byte_s = maxima_byte(sel_s, next_b_s);
   end

   // Framing FSM: snapshot, byte sequencing, completion pulse and dropped-strobe counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= IDLE;
         for (int i = 0; i < MAXIMAS_COUNT; i++) begin
            snap_r[i] <= '0;
         end
         k_r          <= '0;
         b_r          <= 2'd0;
         byte_r       <= 8'h00;
         byte_valid_r <= 1'b0;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
         dropped_r    <= 8'd0;
`ifdef MAXIMAS_UART_TX_CHECKSUM_EN
         csum_r       <= 8'h00;
`endif
      end else begin
         frame_done_r <= 1'b0;
         if (maximas_found_active && (state_r != IDLE) && (dropped_r != 8'hFF)) begin
            dropped_r <= dropped_r + 8'd1;
         end else begin
            dropped_r <= dropped_r;
         end
         case (state_r)
            IDLE: begin
               if (maximas_found_active) begin
                  for (int i = 0; i < MAXIMAS_COUNT; i++) begin
                     snap_r[i] <= maximas[i];
                  end
                  busy_r  <= 1'b1;
                  state_r <= LOAD;
               end else begin
                  state_r <= IDLE;
               end
            end
            LOAD: begin
               byte_r       <= SYNC_BYTE;
               byte_valid_r <= 1'b1;
               state_r      <= SEND_SYNC;
            end
            SEND_SYNC: begin
               if (byte_fire_s) begin
                  byte_r  <= COUNT_BYTE;
`ifdef MAXIMAS_UART_TX_CHECKSUM_EN
                  csum_r  <= COUNT_BYTE;
`endif
                  state_r <= SEND_COUNT;
               end else begin
                  state_r <= SEND_SYNC;
               end
            end
            SEND_COUNT: begin
               if (byte_fire_s) begin
                  byte_r  <= first_byte_s;
`ifdef MAXIMAS_UART_TX_CHECKSUM_EN
                  csum_r  <= csum_update(csum_r, first_byte_s);
`endif
                  k_r     <= '0;
                  b_r     <= 2'd0;
                  state_r <= SEND_DATA;
               end else begin
                  state_r <= SEND_COUNT;
               end
            end
            SEND_DATA: begin
               if (!byte_valid_r) begin
                  // Last byte handed over; wait for its stop bit to finish.
                  if (byte_ready_s) begin
                     busy_r       <= 1'b0;
                     frame_done_r <= 1'b1;
                     state_r      <= DONE;
                  end else begin
                     state_r <= SEND_DATA;
                  end
               end else if (byte_fire_s) begin
                  if (last_s) begin
                     k_r <= '0;
                     b_r <= 2'd0;
`ifdef MAXIMAS_UART_TX_CHECKSUM_EN
                     byte_r  <= csum_r;
                     state_r <= SEND_CSUM;
`else
                     byte_valid_r <= 1'b0;
`endif
                  end else begin
                     k_r    <= next_k_s;
                     b_r    <= next_b_s;
                     byte_r <= next_byte_s;
`ifdef MAXIMAS_UART_TX_CHECKSUM_EN
                     csum_r <= csum_update(csum_r, next_byte_s);
`endif
                  end
               end else begin
                  state_r <= SEND_DATA;
               end
            end
            SEND_CSUM: begin
`ifdef MAXIMAS_UART_TX_CHECKSUM_EN
               if (!byte_valid_r) begin
                  if (byte_ready_s) begin
                     busy_r       <= 1'b0;
                     frame_done_r <= 1'b1;
                     state_r      <= DONE;
                  end else begin
                     state_r <= SEND_CSUM;
                  end
               end else if (byte_fire_s) begin
                  byte_valid_r <= 1'b0;
               end else begin
                  state_r <= SEND_CSUM;
               end
`else
               byte_valid_r <= 1'b0;
               busy_r       <= 1'b0;
               state_r      <= IDLE;
`endif
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               byte_valid_r <= 1'b0;
               busy_r       <= 1'b0;
               state_r      <= IDLE;
            end
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx_byte (
      .clk        (clk),
      .reset      (reset),
      .byte_in    (byte_r),
      .byte_valid (byte_valid_r),
      .byte_ready (byte_ready_s),
      .tx         (tx_s)
   );

   assign tx             = tx_s;
   assign busy           = busy_r;
   assign frame_done     = frame_done_r;
   assign dropped_frames = dropped_r;

endmodule

// File: tb/tb_maximas_uart_tx.sv
// Self-checking bench for maximas_uart_tx (CLKS_PER_BIT=4, MAXIMAS_COUNT=2).
// Honours MAXIMAS_UART_TX_CHECKSUM_EN for the expected frame length.
module tb_maximas_uart_tx;

   localparam int CPB = 4;
   localparam int N   = 2;
`ifdef MAXIMAS_UART_TX_CHECKSUM_EN
   localparam int NB  = 2 + 4 * N + 1;
`else
   localparam int NB  = 2 + 4 * N;
`endif
   localparam int FRAME_CYC = NB * 10 * CPB;
   localparam int D         = 2 + FRAME_CYC;   // sample index of the frame_done cycle

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        strobe = 1'b0;
   logic [24:0] maximas [N-1:0];
   logic        tx;
   logic        busy;
   logic        frame_done;
   logic [7:0]  dropped_frames;

   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q [$];
   int          drop_model = 0;

   always #5 clk = ~clk;

   maximas_uart_tx #(
      .MAXIMAS_COUNT (N),
      .CLKS_PER_BIT  (CPB)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .maximas              (maximas),
      .maximas_found_active (strobe),
      .tx                   (tx),
      .busy                 (busy),
      .frame_done           (frame_done),
      .dropped_frames       (dropped_frames)
   );

   // Reference model: the byte list a frame must carry for a given snapshot.
   function automatic void build_expected(input logic [24:0] m [N-1:0]);
      logic [7:0]  c;
      logic [24:0] w;
      exp_q = {};
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(N));
      c = 8'(N);
      for (int k = 0; k < N; k++) begin
         w = m[k];
         exp_q.push_back({7'd0, w[24]});
         exp_q.push_back(w[23:16]);
         exp_q.push_back(w[15:8]);
         exp_q.push_back(w[7:0]);
         c = c ^ {7'd0, w[24]} ^ w[23:16] ^ w[15:8] ^ w[7:0];
      end
`ifdef MAXIMAS_UART_TX_CHECKSUM_EN
      exp_q.push_back(c);
`endif
   endfunction

   task automatic randomize_maximas();
      for (int k = 0; k < N; k++) maximas[k] = 25'($urandom);
   endtask

   // Returns at the first falling edge after the posedge that samples the strobe.
   task automatic pulse_strobe();
      @(negedge clk);
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
   endtask

   // Logs tx/busy/frame_done for one frame and checks them against exp_q.
   task automatic capture_frame(input string name);
      logic       tx_log [0:D];
      logic       fd_log [0:D];
      logic       bz_log [0:D];
      logic [7:0] eb;
      logic [7:0] got;
      logic       expbit;
      logic       bad;
      int         base;
      int         pulses;
      for (int i = 0; i <= D; i++) begin
         if (i > 0) @(negedge clk);
         tx_log[i] = tx;
         fd_log[i] = frame_done;
         bz_log[i] = busy;
      end
      checks++;
      if (tx_log[0] !== 1'b1 || tx_log[1] !== 1'b1 || tx_log[2] !== 1'b0) begin
         errors++;
         $display("FAIL %s latency: tx after strobe %b%b%b, required 110", name, tx_log[0], tx_log[1], tx_log[2]);
      end
      checks++;
      if (bz_log[0] !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_start: got %b, required 1", name, bz_log[0]);
      end
      for (int j = 0; j < NB; j++) begin
         eb   = exp_q[j];
         base = 2 + j * 10 * CPB;
         bad  = 1'b0;
         got  = 8'h00;
         for (int b = 0; b < 10; b++) begin
            expbit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : eb[b-1];
            for (int c = 0; c < CPB; c++) begin
               if (tx_log[base + b * CPB + c] !== expbit) bad = 1'b1;
            end
            if (b >= 1 && b <= 8) got[b-1] = tx_log[base + b * CPB + CPB / 2];
         end
         checks++;
         if (bad) begin
            errors++;
            $display("FAIL %s byte%0d: got %02h (or bad bit timing), required %02h", name, j, got, eb);
         end
      end
      pulses = 0;
      for (int i = 0; i <= D; i++) if (fd_log[i] === 1'b1) pulses++;
      checks++;
      if (fd_log[D] !== 1'b1 || pulses != 1) begin
         errors++;
         $display("FAIL %s frame_done: at end %b pulses %0d, required 1 pulses 1", name, fd_log[D], pulses);
      end
      checks++;
      if (bz_log[D] !== 1'b0 || bz_log[D-1] !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_end: %b%b, required 10", name, bz_log[D-1], bz_log[D]);
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < N; k++) maximas[k] = 25'd0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || dropped_frames !== 8'd0) begin
         errors++;
         $display("FAIL reset: tx %b busy %b fd %b dropped %0d, required 1 0 0 0", tx, busy, frame_done, dropped_frames);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic_frame();
      maximas[0] = 25'h001ABCD;
      maximas[1] = {9'h1FF, 16'hFF00};
      exp_q = {8'hA5, 8'h02, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'h01, 8'hFF, 8'hFF, 8'h00};
`ifdef MAXIMAS_UART_TX_CHECKSUM_EN
      exp_q.push_back(8'h64);
`endif
      pulse_strobe();
      capture_frame("basic");
      checks++;
      if (dropped_frames !== 8'd0) begin
         errors++;
         $display("FAIL basic dropped: got %0d, required 0", dropped_frames);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_random_frames();
      repeat (3) begin
         randomize_maximas();
         build_expected(maximas);
         pulse_strobe();
         capture_frame("random");
         repeat ($urandom_range(1, 5)) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      randomize_maximas();
      build_expected(maximas);
      pulse_strobe();
      capture_frame("b2b_first");
      randomize_maximas();
      build_expected(maximas);
      pulse_strobe();              // strobe lands in the first IDLE cycle
      capture_frame("b2b_second");
      checks++;
      if (dropped_frames !== 8'(drop_model)) begin
         errors++;
         $display("FAIL b2b dropped: got %0d, required %0d", dropped_frames, drop_model);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_overlap();
      randomize_maximas();
      build_expected(maximas);
      pulse_strobe();
      fork
         capture_frame("overlap");
         begin
            repeat (3) begin
               repeat (40) @(negedge clk);
               randomize_maximas();
               strobe = 1'b1;
               @(negedge clk);
               strobe = 1'b0;
            end
         end
      join
      drop_model = drop_model + 3;
      checks++;
      if (dropped_frames !== 8'(drop_model)) begin
         errors++;
         $display("FAIL overlap dropped: got %0d, required %0d", dropped_frames, drop_model);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_saturation();
      randomize_maximas();
      build_expected(maximas);
      pulse_strobe();
      fork
         capture_frame("saturate");
         begin
            repeat (5) @(negedge clk);
            strobe = 1'b1;
            for (int i = 0; i < 300; i++) begin
               randomize_maximas();
               @(negedge clk);
            end
            strobe = 1'b0;
         end
      join
      drop_model = (drop_model + 300 > 255) ? 255 : drop_model + 300;
      checks++;
      if (dropped_frames !== 8'(drop_model)) begin
         errors++;
         $display("FAIL saturate dropped: got %0d, required %0d", dropped_frames, drop_model);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      randomize_maximas();
      build_expected(maximas);
      pulse_strobe();
      repeat (2 + 4 * 10 * CPB + 1) @(negedge clk);   // inside start bit of byte 5
      checks++;
      if (tx !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midframe_pre: tx %b busy %b, required 0 1", tx, busy);
      end
      reset = 1'b1;
      #1;
      drop_model = 0;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || dropped_frames !== 8'd0) begin
         errors++;
         $display("FAIL midframe_reset: tx %b busy %b dropped %0d, required 1 0 0", tx, busy, dropped_frames);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      randomize_maximas();
      build_expected(maximas);
      pulse_strobe();
      capture_frame("after_reset");
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_random_frames();
      test_back_to_back();
      test_overlap();
      test_saturation();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
